// File: rtl/half_subtractor_pkg.sv
// Shared defaults for the half-subtractor block.
package half_subtractor_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;
endpackage

// File: rtl/half_sub_cell.sv
// Single-bit combinational half subtractor: a - b.
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b;
  assign borrow = ~a & b;
endmodule

// File: rtl/half_subtractor.sv
// Registered WIDTH-lane half subtractor with sticky borrow flag and saturating borrow counter.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             out_valid,
  output logic             borrow_seen,
  output logic [CNT_W-1:0] borrow_count
);
  logic [WIDTH-1:0] cell_diff;
  logic [WIDTH-1:0] cell_borrow;
  logic             any_borrow;

  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] borrow_reg;
  logic             out_valid_reg;
  logic             borrow_seen_reg;
  logic             borrow_seen_next;
  logic [CNT_W-1:0] borrow_count_reg;
  logic [CNT_W-1:0] borrow_count_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      half_sub_cell u_cell (
        .a      (a[gi]),
        .b      (b[gi]),
        .diff   (cell_diff[gi]),
        .borrow (cell_borrow[gi])
      );
    end
  endgenerate

  // Gating with in_valid keeps undriven a/b on idle cycles from reaching the counter.
  assign any_borrow = in_valid & (|cell_borrow);

  always_comb begin
    borrow_seen_next  = borrow_seen_reg;
    borrow_count_next = borrow_count_reg;
    if (clr) begin
      // A borrowing sample in the clear cycle counts as the first event after the clear.
      borrow_seen_next  = any_borrow;
      borrow_count_next = any_borrow ? CNT_W'(1) : '0;
    end else if (any_borrow) begin
      borrow_seen_next = 1'b1;
      if (borrow_count_reg != '1) begin
        borrow_count_next = borrow_count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_reg         <= '0;
      borrow_reg       <= '0;
      out_valid_reg    <= 1'b0;
      borrow_seen_reg  <= 1'b0;
      borrow_count_reg <= '0;
    end else begin
      out_valid_reg    <= in_valid;
      borrow_seen_reg  <= borrow_seen_next;
      borrow_count_reg <= borrow_count_next;
      if (in_valid) begin
        diff_reg   <= cell_diff;
        borrow_reg <= cell_borrow;
      end
    end
  end

  assign diff         = diff_reg;
  assign borrow       = borrow_reg;
  assign out_valid    = out_valid_reg;
  assign borrow_seen  = borrow_seen_reg;
  assign borrow_count = borrow_count_reg;
endmodule

// File: tb/tb_half_subtractor.sv
// Directed, table-driven bench for half_subtractor at WIDTH=1/CNT_W=16 and WIDTH=4/CNT_W=4.
module tb_half_subtractor;
  logic clk = 1'b0;
  logic rst;

  logic [0:0]  a1, b1, d1, bo1;
  logic        v1, clr1, ov1, bs1;
  logic [15:0] bc1;

  logic [3:0]  a4, b4, d4, bo4;
  logic        v4, clr4, ov4, bs4;
  logic [3:0]  bc4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_diff;
    logic [3:0] exp_borrow;
  } vec_t;

  vec_t vec1 [4];
  vec_t vec4 [5];

  always #50 clk = ~clk;

  half_subtractor #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .clr(clr1),
    .diff(d1), .borrow(bo1), .out_valid(ov1), .borrow_seen(bs1), .borrow_count(bc1)
  );

  half_subtractor #(.WIDTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .clr(clr4),
    .diff(d4), .borrow(bo4), .out_valid(ov4), .borrow_seen(bs4), .borrow_count(bc4)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      $display("ok   %s: %0h", name, actual);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    logic [3:0] held_d;
    logic [3:0] held_b;

    vec1[0] = '{4'b0, 4'b0, 4'b0, 4'b0};
    vec1[1] = '{4'b0, 4'b1, 4'b1, 4'b1};
    vec1[2] = '{4'b1, 4'b0, 4'b1, 4'b0};
    vec1[3] = '{4'b1, 4'b1, 4'b0, 4'b0};

    vec4[0] = '{4'b0101, 4'b0011, 4'b0110, 4'b0010};
    vec4[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vec4[2] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
    vec4[3] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    vec4[4] = '{4'b1010, 4'b1100, 4'b0110, 4'b0100};

    rst = 1'b1;
    a1 = '0; b1 = '0; v1 = 1'b0; clr1 = 1'b0;
    a4 = '0; b4 = '0; v4 = 1'b0; clr4 = 1'b0;
    repeat (2) tick();
    check("rst w1 diff", 32'(d1), 0);
    check("rst w1 out_valid", 32'(ov1), 0);
    check("rst w4 diff/borrow", 32'({d4, bo4}), 0);
    check("rst w4 seen/count", 32'({bs4, bc4}), 0);
    rst = 1'b0;
    tick();

    // Width-1 truth table, one vector per 100-unit clock period.
    for (int i = 0; i < 4; i++) begin
      a1 = vec1[i].a[0]; b1 = vec1[i].b[0]; v1 = 1'b1;
      tick();
      check($sformatf("w1 vec%0d diff", i), 32'(d1), 32'(vec1[i].exp_diff));
      check($sformatf("w1 vec%0d borrow", i), 32'(bo1), 32'(vec1[i].exp_borrow));
      check($sformatf("w1 vec%0d out_valid", i), 32'(ov1), 1);
    end
    v1 = 1'b0;
    check("w1 borrow_count", 32'(bc1), 1);
    check("w1 borrow_seen", 32'(bs1), 1);

    // Width-4 vectors with a small counter model.
    exp_cnt = '0;
    for (int i = 0; i < 5; i++) begin
      a4 = vec4[i].a; b4 = vec4[i].b; v4 = 1'b1;
      if (vec4[i].exp_borrow != 0 && exp_cnt != 4'hf) exp_cnt++;
      tick();
      check($sformatf("w4 vec%0d diff", i), 32'(d4), 32'(vec4[i].exp_diff));
      check($sformatf("w4 vec%0d borrow", i), 32'(bo4), 32'(vec4[i].exp_borrow));
      check($sformatf("w4 vec%0d out_valid", i), 32'(ov4), 1);
      check($sformatf("w4 vec%0d count", i), 32'(bc4), 32'(exp_cnt));
    end

    // Hold: idle cycles with random and unknown a/b must not disturb state.
    a4 = 4'b0101; b4 = 4'b0011; v4 = 1'b1;
    exp_cnt = (exp_cnt == 4'hf) ? exp_cnt : exp_cnt + 4'd1;
    tick();
    held_d = 4'b0110; held_b = 4'b0010;
    v4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a4 = 'x; b4 = 'x; end
      else begin a4 = 4'($urandom); b4 = 4'($urandom); end
      tick();
      check($sformatf("hold%0d diff/borrow", i), 32'({d4, bo4}), 32'({held_d, held_b}));
      check($sformatf("hold%0d out_valid", i), 32'(ov4), 0);
      check($sformatf("hold%0d count", i), 32'(bc4), 32'(exp_cnt));
    end

    // Saturation at 15 with 20 borrowing samples.
    a4 = 4'b0000; b4 = 4'b0001; v4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_cnt != 4'hf) exp_cnt++;
      tick();
      check($sformatf("sat%0d count", i), 32'(bc4), 32'(exp_cnt));
    end
    check("sat final count", 32'(bc4), 15);

    // clr coinciding with a borrowing sample.
    clr4 = 1'b1;
    tick();
    check("clr+borrow count", 32'(bc4), 1);
    check("clr+borrow seen", 32'(bs4), 1);
    v4 = 1'b0;
    tick();
    check("clr idle count", 32'(bc4), 0);
    check("clr idle seen", 32'(bs4), 0);
    a4 = 4'b1100; b4 = 4'b0100; v4 = 1'b1;
    tick();
    check("clr no-borrow diff", 32'(d4), 32'(4'b1000));
    check("clr no-borrow out_valid", 32'(ov4), 1);
    check("clr no-borrow count", 32'(bc4), 0);
    clr4 = 1'b0;

    // Asynchronous reset between edges during traffic.
    a4 = 4'b0011; b4 = 4'b0101; v4 = 1'b1;
    tick();
    check("pre-rst diff", 32'(d4), 32'(4'b0110));
    check("pre-rst borrow", 32'(bo4), 32'(4'b0100));
    #20 rst = 1'b1;
    #1;
    check("async rst diff/borrow", 32'({d4, bo4}), 0);
    check("async rst valid/seen/count", 32'({ov4, bs4, bc4}), 0);
    tick();
    rst = 1'b0; v4 = 1'b0;
    tick();
    check("post-rst out_valid", 32'(ov4), 0);
    check("post-rst diff", 32'(d4), 0);
    a4 = 4'b0110; b4 = 4'b1010; v4 = 1'b1;
    tick();
    check("post-rst sample diff", 32'(d4), 32'(4'b1100));
    check("post-rst sample borrow", 32'(bo4), 32'(4'b1000));
    check("post-rst sample count", 32'({bs4, bc4}), 32'({1'b1, 4'd1}));
    v4 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
